// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one uart transmitter among NUM_REQ
// byte streams, with a per-grant burst cap and a stall watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1024,
    localparam int IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   uart_transmit,
    output logic [7:0]             uart_tx_byte,
    input  logic                   uart_is_transmitting,
    output logic                   busy,
    output logic                   err_timeout
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]          burst_cnt_q, burst_cnt_d;
    logic [15:0]         wd_cnt_q, wd_cnt_d;
    logic                last_q, last_d;
    logic                xmit_q, xmit_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                err_q, err_d;

    logic [IDXW-1:0]     pick_idx;
    logic                pick_found;
    logic                release_now;

    // First valid requester starting at rr_ptr and wrapping.
    always_comb begin : p_pick
        int cand;
        cand       = 0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        last_d      = last_q;
        xmit_d      = 1'b0;
        tx_byte_d   = tx_byte_q;
        err_d       = 1'b0;
        req_ready   = '0;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d       = pick_idx;
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    burst_cnt_d = '0;
                    wd_cnt_d    = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (req_valid[idx_q]) begin
                    // A valid byte waiting on a busy uart is not a stall.
                    if (!uart_is_transmitting) begin
                        req_ready[idx_q] = 1'b1;
                        tx_byte_d        = req_data[8*idx_q +: 8];
                        xmit_d           = 1'b1;
                        last_d           = req_last[idx_q];
                        burst_cnt_d      = burst_cnt_q + 8'd1;
                        wd_cnt_d         = '0;
                        state_d          = WAIT_START;
                    end
                end else if (wd_cnt_q == 16'(TIMEOUT - 1)) begin
                    release_now = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            WAIT_START: begin
                if (uart_is_transmitting) begin
                    wd_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end else if (wd_cnt_q == 16'(TIMEOUT - 1)) begin
                    release_now = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    if (last_q || (MAX_BURST != 0 && burst_cnt_q == 8'(MAX_BURST))) begin
                        release_now = 1'b1;
                    end else begin
                        wd_cnt_d = '0;
                        state_d  = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_now) begin
            grant_d  = '0;
            rr_ptr_d = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wd_cnt_q    <= '0;
            last_q      <= 1'b0;
            xmit_q      <= 1'b0;
            tx_byte_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            last_q      <= last_d;
            xmit_q      <= xmit_d;
            tx_byte_q   <= tx_byte_d;
            err_q       <= err_d;
        end
    end

    assign grant         = grant_q;
    assign uart_transmit = xmit_q;
    assign uart_tx_byte  = tx_byte_q;
    assign busy          = (state_q != IDLE);
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-based requesters plus a simple uart busy model
// that logs every byte it starts; expected byte orders and timings are hand-derived.
module tb_uart_tx_arbiter;

    localparam int NR      = 4;
    localparam int MAXB    = 2;
    localparam int TMO     = 32;
    localparam int FRAME   = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [8*NR-1:0]   req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic              uart_transmit;
    logic [7:0]        uart_tx_byte;
    logic              uart_is_transmitting;
    logic              busy;
    logic              err_timeout;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MAXB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .grant(grant), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_is_transmitting(uart_is_transmitting), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] q_data [NR][$];
    logic       q_last [NR][$];
    logic [7:0] tx_log [$];

    // uart model: starts a frame on a transmit pulse, busy for FRAME cycles
    logic tx_busy = 1'b0;
    logic tie_low = 1'b0;
    int   tx_cnt  = 0;
    assign uart_is_transmitting = tie_low ? 1'b0 : tx_busy;

    always @(posedge clk) begin
        if (tx_busy) begin
            if (tx_cnt == 1) tx_busy <= 1'b0;
            tx_cnt <= tx_cnt - 1;
        end else if (uart_transmit && !tie_low) begin
            tx_busy <= 1'b1;
            tx_cnt  <= FRAME;
            tx_log.push_back(uart_tx_byte);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] && q_data[i].size() > 0) begin
                void'(q_data[i].pop_front());
                void'(q_last[i].pop_front());
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = q_data[i].size() > 0;
            req_data[8*i +: 8] = (q_data[i].size() > 0) ? q_data[i][0] : 8'h00;
            req_last[i]        = (q_last[i].size() > 0) ? q_last[i][0] : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b, input logic l);
        q_data[i].push_back(b);
        q_last[i].push_back(l);
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NR; i++) if (q_data[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < NR; i++) begin
            q_data[i].delete();
            q_last[i].delete();
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tx_log.delete();
    endtask

    // Wait until all packets are sent and everything is idle; ORs grants seen on the way.
    task automatic wait_all(input string tag, input int budget, output logic [NR-1:0] seen);
        int n;
        n = 0;
        seen = '0;
        do begin
            @(negedge clk);
            seen |= grant;
            n++;
        end while (!(queues_empty() && !busy && !tx_busy) && n < budget);
        if (n >= budget) chk({tag, "_wait_timeout"}, 32'(n), 32'(budget - 1));
    endtask

    task automatic wait_ready(input int i, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!req_ready[i] && n < budget);
        if (n >= budget) chk("wait_ready_timeout", 32'(n), 32'(budget - 1));
    endtask

    task automatic chk_log(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, 32'(tx_log.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++)
            chk($sformatf("%s_b%0d", tag, k), (k < tx_log.size()) ? 32'(tx_log[k]) : 32'hffff, 32'(exp[k]));
    endtask

    initial begin
        logic [NR-1:0] seen;
        int cnt;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_xmit", 32'(uart_transmit), 0);
        chk("rst_byte", 32'(uart_tx_byte), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst = 1'b0;

        // 1: single requester, 2-byte packet, latency of the start pulse
        push(0, 8'h55, 1'b0);
        push(0, 8'hA3, 1'b1);
        wait_ready(0, 20);
        chk("t1_grant", 32'(grant), 32'h1);
        @(posedge clk); #1;
        chk("t1_xmit", 32'(uart_transmit), 1);
        chk("t1_byte", 32'(uart_tx_byte), 32'h55);
        @(posedge clk); #1;
        chk("t1_xmit_pulse", 32'(uart_transmit), 0);
        chk("t1_uart_start", 32'(uart_is_transmitting), 1);
        chk("t1_ready_busy", 32'(req_ready), 0);
        wait_all("t1", 400, seen);
        chk("t1_grants_seen", 32'(seen), 32'h1);
        chk("t1_grant_end", 32'(grant), 0);
        chk_log("t1", '{8'h55, 8'hA3});

        // 2: all four requesters at once from reset
        do_reset();
        for (int i = 0; i < NR; i++) begin
            push(i, 8'(8'h10 * (i + 1)), 1'b0);
            push(i, 8'(8'h10 * (i + 1) + 1), 1'b1);
        end
        wait_all("t2", 1500, seen);
        chk("t2_grants_seen", 32'(seen), 32'hF);
        chk_log("t2", '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41});

        // 3: burst cap of 2 interleaves req2 into req1's 5-byte packet
        do_reset();
        for (int k = 0; k < 5; k++) push(1, 8'(8'hA0 + k), k == 4);
        push(2, 8'hB0, 1'b1);
        wait_all("t3", 1500, seen);
        chk_log("t3", '{8'hA0, 8'hA1, 8'hB0, 8'hA2, 8'hA3, 8'hA4});

        // 4: req0 stalls mid-packet, watchdog passes the grant to req1
        do_reset();
        push(0, 8'h01, 1'b0);
        push(1, 8'h71, 1'b1);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!err_timeout && cnt < 500);
        chk("t4_err_seen", 32'(err_timeout), 1);
        chk("t4_grant_rel", 32'(grant), 0);
        chk("t4_busy_rel", 32'(busy), 0);
        @(posedge clk); #1;
        chk("t4_err_pulse", 32'(err_timeout), 0);
        chk("t4_grant_next", 32'(grant), 32'h2);
        wait_all("t4", 400, seen);
        chk_log("t4", '{8'h01, 8'h71});

        // 5: uart never starts, watchdog fires TIMEOUT cycles after the accept
        do_reset();
        tie_low = 1'b1;
        push(0, 8'h5A, 1'b1);
        wait_ready(0, 20);
        @(posedge clk); #1;
        chk("t5_xmit", 32'(uart_transmit), 1);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!err_timeout && cnt < 200);
        chk("t5_err_cycles", 32'(cnt), 32'(TMO));
        chk("t5_busy", 32'(busy), 0);
        chk("t5_grant", 32'(grant), 0);
        @(posedge clk); #1;
        chk("t5_err_pulse", 32'(err_timeout), 0);
        tie_low = 1'b0;

        // 6: reset in WAIT_DONE aborts the packet
        do_reset();
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!tx_busy && cnt < 50);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            q_data[i].delete();
            q_last[i].delete();
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_grant", 32'(grant), 0);
        chk("t6_xmit", 32'(uart_transmit), 0);
        chk("t6_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk_log("t6", '{8'h11});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
